// File: rtl/bc_pkg.sv
// Shared types and constants for the Branch Conditional unit.
// Body fields are stored MSB-first: BO[0] lives in body[27], LK in body[0].
package bc_pkg;

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned ID_W   = 64;
  localparam int unsigned OPC_W  = 12;
  localparam int unsigned BODY_W = 28;

  localparam logic [OPC_W-1:0] BC_OPCODE      = 12'd24;
  localparam int unsigned      BRANCH_UNIT_ID = 6;

  localparam int unsigned BO_LSB = 23;
  localparam int unsigned BI_LSB = 18;
  localparam int unsigned BD_LSB = 2;
  localparam int unsigned AA_BIT = 1;
  localparam int unsigned LK_BIT = 0;

  typedef struct packed {
    logic [OPC_W-1:0]  opcode;
    logic [ADDR_W-1:0] cia;
    logic [ID_W-1:0]   majId;
    logic              is64;
    logic [BODY_W-1:0] body;
  } bc_entry_t;

  function automatic logic [ADDR_W-1:0] bd_ea(input logic [15:0] bd);
    return {{(ADDR_W-16){bd[15]}}, bd};
  endfunction

endpackage

// File: rtl/bc_input_queue.sv
// Generic small FIFO with full/empty status and a sticky overflow flag.
// A push while full is dropped, even if a pop happens on the same edge.
module bc_input_queue #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push_ok, pop_ok;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full_o     = (cnt_q == CW'(DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign overflow_o = ovf_q;
  assign data_o     = mem_q[rd_q];
  assign push_ok    = push_i && !full_o;
  assign pop_ok     = pop_i && !empty_o;

  always_comb begin
    wr_d  = push_ok ? ptr_inc(wr_q) : wr_q;
    rd_d  = pop_ok ? ptr_inc(rd_q) : rd_q;
    ovf_d = ovf_q | (push_i & full_o);
    cnt_d = cnt_q;
    if (push_ok && !pop_ok) cnt_d = cnt_q + CW'(1);
    else if (!push_ok && pop_ok) cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clock_i) begin
    if (push_ok) mem_q[wr_q] <= data_i;
  end

endmodule

// File: rtl/branch_conditional_unit.sv
// Branch Conditional back-end: input queue, BO/BI resolve, CTR/LR ownership.
// Optional macro BC_MISPREDICT_EN adds a static-prediction mispredict_o output.
module branch_conditional_unit
  import bc_pkg::*;
#(
  parameter int unsigned      addressWidth            = 64,
  parameter int unsigned      instructionCounterWidth = 64,
  parameter int unsigned      opcodeSize              = 12,
  parameter int unsigned      bodySize                = 28,
  parameter int unsigned      queueDepth              = 2,
  parameter logic [OPC_W-1:0] bcOpcode                = BC_OPCODE
) (
  input  logic                               clock_i,
  input  logic                               reset_i,
  input  logic                               enable_i,
  input  logic [opcodeSize-1:0]              opcode_i,
  input  logic [addressWidth-1:0]            instructionAddress_i,
  input  logic [instructionCounterWidth-1:0] instMajId_i,
  input  logic                               is64Bit_i,
  input  logic [bodySize-1:0]                instructionBody_i,
  input  logic [31:0]                        crBits_i,
  input  logic                               ctrWrEn_i,
  input  logic [addressWidth-1:0]            ctrWrData_i,
  input  logic                               lrWrEn_i,
  input  logic [addressWidth-1:0]            lrWrData_i,
  input  logic                               stall_i,
  output logic                               stall_o,
  output logic                               outValid_o,
  output logic                               taken_o,
  output logic [addressWidth-1:0]            nextAddress_o,
  output logic [instructionCounterWidth-1:0] majId_o,
  output logic                               illegal_o,
  output logic                               overflow_o,
  output logic [addressWidth-1:0]            ctr_o,
  output logic [addressWidth-1:0]            lr_o
`ifdef BC_MISPREDICT_EN
  ,
  output logic                               mispredict_o
`endif
);

  bc_entry_t q_in, head;
  logic      q_full, q_empty, pop;

  logic              valid_q, valid_d, taken_q, taken_d, illegal_q, illegal_d;
  logic [ADDR_W-1:0] nia_q, nia_d, ctr_q, ctr_d, lr_q, lr_d;
  logic [ID_W-1:0]   majid_q, majid_d;

  logic [4:0]        bo, bi, cr_idx;
  logic [15:0]       bd;
  logic              aa, lk, legal, ctrm_nz, ctr_ok, cond_ok, tk;
  logic [ADDR_W-1:0] ctr_n, seq, tgt, nia;

  assign q_in = '{opcode: opcode_i, cia: instructionAddress_i, majId: instMajId_i,
                  is64: is64Bit_i, body: instructionBody_i};

  bc_input_queue #(.WIDTH($bits(bc_entry_t)), .DEPTH(queueDepth)) u_queue (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .push_i     (enable_i),
    .data_i     (q_in),
    .pop_i      (pop),
    .data_o     (head),
    .full_o     (q_full),
    .empty_o    (q_empty),
    .overflow_o (overflow_o)
  );

  assign pop = !q_empty && (!valid_q || !stall_i);

  // BO bit n (big-endian) is bo[4-n]; CR bit n (big-endian) is crBits_i[31-n].
  always_comb begin
    bo      = head.body[BO_LSB +: 5];
    bi      = head.body[BI_LSB +: 5];
    bd      = head.body[BD_LSB +: 16];
    aa      = head.body[AA_BIT];
    lk      = head.body[LK_BIT];
    legal   = (head.opcode == bcOpcode);
    cr_idx  = 5'd31 - bi;
    ctr_n   = bo[2] ? ctr_q : ctr_q - ADDR_W'(1);
    ctrm_nz = head.is64 ? (ctr_n != '0) : (ctr_n[31:0] != '0);
    ctr_ok  = bo[2] | (ctrm_nz ^ bo[1]);
    cond_ok = bo[4] | (crBits_i[cr_idx] == bo[3]);
    tk      = ctr_ok & cond_ok;
    seq     = head.cia + ADDR_W'(4);
    tgt     = aa ? bd_ea(bd) : head.cia + bd_ea(bd);
    nia     = tk ? tgt : seq;
    if (!head.is64) nia[63:32] = '0;

    valid_d   = valid_q;
    taken_d   = taken_q;
    nia_d     = nia_q;
    majid_d   = majid_q;
    illegal_d = illegal_q;
    if (pop) begin
      valid_d   = 1'b1;
      taken_d   = legal & tk;
      nia_d     = legal ? nia : seq;
      majid_d   = head.majId;
      illegal_d = !legal;
    end else if (!stall_i) begin
      valid_d = 1'b0;
    end

    ctr_d = ctr_q;
    if (ctrWrEn_i) ctr_d = ctrWrData_i;
    else if (pop && legal) ctr_d = ctr_n;

    lr_d = lr_q;
    if (lrWrEn_i) lr_d = lrWrData_i;
    else if (pop && legal && lk) lr_d = head.is64 ? seq : {32'h0, seq[31:0]};
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      valid_q   <= 1'b0;
      taken_q   <= 1'b0;
      nia_q     <= '0;
      majid_q   <= '0;
      illegal_q <= 1'b0;
      ctr_q     <= '0;
      lr_q      <= '0;
    end else begin
      valid_q   <= valid_d;
      taken_q   <= taken_d;
      nia_q     <= nia_d;
      majid_q   <= majid_d;
      illegal_q <= illegal_d;
      ctr_q     <= ctr_d;
      lr_q      <= lr_d;
    end
  end

`ifdef BC_MISPREDICT_EN
  logic mis_q, mis_d;

  // Static guess: backward displacement or branch-always predicts taken.
  always_comb begin
    mis_d = mis_q;
    if (pop) mis_d = legal & ((bd[15] | (bo[4] & bo[2])) != tk);
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) mis_q <= 1'b0;
    else          mis_q <= mis_d;
  end

  assign mispredict_o = mis_q;
`endif

  assign stall_o       = q_full;
  assign outValid_o    = valid_q;
  assign taken_o       = taken_q;
  assign nextAddress_o = nia_q;
  assign majId_o       = majid_q;
  assign illegal_o     = illegal_q;
  assign ctr_o         = ctr_q;
  assign lr_o          = lr_q;

endmodule

// File: tb/tb_branch_conditional_unit.sv
// Self-checking bench for branch_conditional_unit: per-cycle model comparison
// plus directed literal expectations.
module tb_branch_conditional_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        enable_i = 1'b0;
  logic [11:0] opcode_i = '0;
  logic [63:0] cia_i = '0;
  logic [63:0] maj_i = '0;
  logic        is64_i = 1'b0;
  logic [27:0] body_i = '0;
  logic [31:0] cr_i = '0;
  logic        ctrWrEn_i = 1'b0;
  logic [63:0] ctrWrData_i = '0;
  logic        lrWrEn_i = 1'b0;
  logic [63:0] lrWrData_i = '0;
  logic        stall_i = 1'b0;

  logic        stall_o, outValid_o, taken_o, illegal_o, overflow_o;
  logic [63:0] nextAddress_o, majId_o, ctr_o, lr_o;

  int n_cmp = 0;
  int n_bad = 0;

  branch_conditional_unit dut (
    .clock_i              (clk),
    .reset_i              (rst_n),
    .enable_i             (enable_i),
    .opcode_i             (opcode_i),
    .instructionAddress_i (cia_i),
    .instMajId_i          (maj_i),
    .is64Bit_i            (is64_i),
    .instructionBody_i    (body_i),
    .crBits_i             (cr_i),
    .ctrWrEn_i            (ctrWrEn_i),
    .ctrWrData_i          (ctrWrData_i),
    .lrWrEn_i             (lrWrEn_i),
    .lrWrData_i           (lrWrData_i),
    .stall_i              (stall_i),
    .stall_o              (stall_o),
    .outValid_o           (outValid_o),
    .taken_o              (taken_o),
    .nextAddress_o        (nextAddress_o),
    .majId_o              (majId_o),
    .illegal_o            (illegal_o),
    .overflow_o           (overflow_o),
    .ctr_o                (ctr_o),
    .lr_o                 (lr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    longint unsigned op;
    longint unsigned cia;
    longint unsigned maj;
    bit              is64;
    longint unsigned body;
  } pkt_t;

  pkt_t            mq[$];
  bit              m_valid = 0, m_taken = 0, m_illegal = 0, m_ovf = 0;
  longint unsigned m_nia = 0, m_maj = 0, m_ctr = 0, m_lr = 0;

  localparam longint unsigned LO32 = 64'h0000_0000_FFFF_FFFF;

  // BO bit i counted from the most significant end of the 5-bit field.
  function automatic bit bo_at(input longint unsigned body, input int i);
    return ((body >> 23) >> (4 - i)) & 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int              n;
    bit              do_pop, do_push, ctr_ok, cond_ok, tk, zero;
    pkt_t            p, np;
    longint unsigned new_ctr, new_lr, seq, ctrn, tgt, nia;
    longint          ea, bdv;
    int              bi;
    if (!rst_n) begin
      mq.delete();
      m_valid = 0; m_taken = 0; m_illegal = 0; m_ovf = 0;
      m_nia = 0; m_maj = 0; m_ctr = 0; m_lr = 0;
    end else begin
      n       = mq.size();
      do_pop  = (n > 0) && (!m_valid || !stall_i);
      do_push = enable_i && (n < 2);
      if (enable_i && n >= 2) m_ovf = 1;
      new_ctr = m_ctr;
      new_lr  = m_lr;
      if (do_pop) begin
        p = mq.pop_front();
        m_valid = 1;
        m_maj   = p.maj;
        seq     = p.cia + 4;
        if (p.op != 24) begin
          m_illegal = 1; m_taken = 0; m_nia = seq;
        end else begin
          m_illegal = 0;
          ctrn    = bo_at(p.body, 2) ? m_ctr : m_ctr - 1;
          zero    = p.is64 ? (ctrn == 0) : ((ctrn & LO32) == 0);
          ctr_ok  = bo_at(p.body, 2) || ((!zero) != bo_at(p.body, 3));
          bi      = int'((p.body >> 18) & 31);
          cond_ok = bo_at(p.body, 0) || (((cr_i >> (31 - bi)) & 1) == bo_at(p.body, 1));
          tk      = ctr_ok && cond_ok;
          bdv     = longint'((p.body >> 2) & 'hFFFF);
          if (bdv >= 32768) bdv = bdv - 65536;
          ea      = bdv;
          tgt     = ((p.body >> 1) & 1) ? longint'(ea) : p.cia + longint'(ea);
          nia     = tk ? tgt : seq;
          if (!p.is64) nia = nia & LO32;
          m_taken = tk;
          m_nia   = nia;
          new_ctr = ctrn;
          if (p.body & 1) new_lr = p.is64 ? seq : (seq & LO32);
        end
      end else if (!stall_i) begin
        m_valid = 0;
      end
      m_ctr = ctrWrEn_i ? ctrWrData_i : new_ctr;
      m_lr  = lrWrEn_i ? lrWrData_i : new_lr;
      if (do_push) begin
        np.op = opcode_i; np.cia = cia_i; np.maj = maj_i; np.is64 = is64_i; np.body = body_i;
        mq.push_back(np);
      end
    end
  end

  always @(posedge clk) begin
    #1;
    chk("outValid", outValid_o, m_valid);
    chk("stall_o", stall_o, (mq.size() == 2));
    chk("overflow", overflow_o, m_ovf);
    chk("ctr", ctr_o, m_ctr);
    chk("lr", lr_o, m_lr);
    if (m_valid) begin
      chk("taken", taken_o, m_taken);
      chk("nia", nextAddress_o, m_nia);
      chk("majId", majId_o, m_maj);
      chk("illegal", illegal_o, m_illegal);
    end
  end

  // ---------------- directed stimulus ----------------
  function automatic logic [27:0] mk(input logic [4:0] bo, input logic [4:0] bi,
                                     input logic [15:0] bd, input logic aa, input logic lk);
    return {bo, bi, bd, aa, lk};
  endfunction

  task automatic drive(input logic [11:0] op, input logic [63:0] cia, input logic [63:0] maj,
                       input logic is64, input logic [27:0] body);
    enable_i = 1'b1; opcode_i = op; cia_i = cia; maj_i = maj; is64_i = is64; body_i = body;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst outValid", outValid_o, 0);
    chk("rst stall", stall_o, 0);
    chk("rst ctr", ctr_o, 0);
    chk("rst lr", lr_o, 0);
    chk("rst overflow", overflow_o, 0);
    rst_n = 1'b1;

    // branch always, relative
    @(negedge clk) drive(24, 64'h1000, 1, 1, mk(5'b10100, 0, 16'h0040, 0, 0));
    @(negedge clk) enable_i = 0;
    chk("latency early", outValid_o, 0);
    @(negedge clk);
    chk("bra valid", outValid_o, 1);
    chk("bra taken", taken_o, 1);
    chk("bra nia", nextAddress_o, 64'h1040);
    chk("bra ctr", ctr_o, 0);

    // bdnz with CTR=2, back-to-back, then from CTR=0
    @(negedge clk) begin ctrWrEn_i = 1; ctrWrData_i = 2; end
    @(negedge clk) begin ctrWrEn_i = 0; drive(24, 64'h3000, 2, 1, mk(5'b10000, 0, 16'h0100, 0, 0)); end
    @(negedge clk) drive(24, 64'h3100, 3, 1, mk(5'b10000, 0, 16'h0100, 0, 0));
    @(negedge clk) enable_i = 0;
    chk("bdnz1 taken", taken_o, 1);
    chk("bdnz1 nia", nextAddress_o, 64'h3100);
    chk("bdnz1 ctr", ctr_o, 1);
    @(negedge clk);
    chk("bdnz2 taken", taken_o, 0);
    chk("bdnz2 nia", nextAddress_o, 64'h3104);
    chk("bdnz2 ctr", ctr_o, 0);
    @(negedge clk) drive(24, 64'h3200, 4, 1, mk(5'b10000, 0, 16'h0100, 0, 0));
    @(negedge clk) enable_i = 0;
    @(negedge clk);
    chk("bdnz3 ctr wrap", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("bdnz3 taken", taken_o, 1);
    chk("bdnz3 nia", nextAddress_o, 64'h3300);

    // CR condition with link, then 32-bit absolute negative target
    @(negedge clk) begin cr_i = 32'h2000_0000; drive(24, 64'h2000, 5, 1, mk(5'b01100, 2, 16'h0040, 0, 1)); end
    @(negedge clk) enable_i = 0;
    @(negedge clk);
    chk("cr taken", taken_o, 1);
    chk("cr nia", nextAddress_o, 64'h2040);
    chk("cr lr", lr_o, 64'h2004);
    @(negedge clk) drive(24, 64'h2000, 6, 0, mk(5'b01100, 2, 16'hFFF0, 1, 1));
    @(negedge clk) enable_i = 0;
    @(negedge clk);
    chk("abs32 taken", taken_o, 1);
    chk("abs32 nia", nextAddress_o, 64'h0000_0000_FFFF_FFF0);
    chk("abs32 lr", lr_o, 64'h2004);

    // backpressure: 4 pushes while stalled, 4th dropped
    @(negedge clk) begin stall_i = 1; drive(24, 64'h4000, 10, 1, mk(5'b10100, 0, 16'h0010, 0, 0)); end
    @(negedge clk) drive(24, 64'h4010, 11, 1, mk(5'b10100, 0, 16'h0010, 0, 0));
    @(negedge clk) drive(24, 64'h4020, 12, 1, mk(5'b10100, 0, 16'h0010, 0, 0));
    @(negedge clk) drive(24, 64'h4030, 13, 1, mk(5'b10100, 0, 16'h0010, 0, 0));
    @(negedge clk) begin
      enable_i = 0;
      chk("bp stall_o", stall_o, 1);
      chk("bp overflow", overflow_o, 1);
      chk("bp held majId", majId_o, 10);
      stall_i = 0;
    end
    @(negedge clk);
    chk("bp order 2", majId_o, 11);
    chk("bp stall_o drop", stall_o, 0);
    @(negedge clk);
    chk("bp order 3", majId_o, 12);
    @(negedge clk);
    chk("bp drained", outValid_o, 0);

    // illegal opcode
    @(negedge clk) drive(5, 64'h5000, 20, 1, mk(5'b10100, 0, 16'h0040, 0, 1));
    @(negedge clk) enable_i = 0;
    @(negedge clk);
    chk("ill illegal", illegal_o, 1);
    chk("ill taken", taken_o, 0);
    chk("ill nia", nextAddress_o, 64'h5004);
    chk("ill lr", lr_o, 64'h2004);
    chk("ill ctr", ctr_o, 64'hFFFF_FFFF_FFFF_FFFF);

    // mtctr/mtlr on the same edge as a bdnz with link resolves
    @(negedge clk) drive(24, 64'h6000, 21, 1, mk(5'b10000, 0, 16'h0100, 0, 1));
    @(negedge clk) begin
      enable_i = 0; ctrWrEn_i = 1; ctrWrData_i = 64'h55; lrWrEn_i = 1; lrWrData_i = 64'h77;
    end
    @(negedge clk) begin ctrWrEn_i = 0; lrWrEn_i = 0; end
    chk("conf ctr", ctr_o, 64'h55);
    chk("conf lr", lr_o, 64'h77);
    chk("conf taken", taken_o, 1);
    chk("conf nia", nextAddress_o, 64'h6100);

    // reset mid-stream with two packets queued
    @(negedge clk) begin stall_i = 1; drive(24, 64'h7000, 30, 1, mk(5'b10100, 0, 16'h0010, 0, 0)); end
    @(negedge clk) drive(24, 64'h7010, 31, 1, mk(5'b10100, 0, 16'h0010, 0, 0));
    @(negedge clk) drive(24, 64'h7020, 32, 1, mk(5'b10100, 0, 16'h0010, 0, 0));
    @(negedge clk) enable_i = 0;
    chk("pre-rst stall_o", stall_o, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst outValid", outValid_o, 0);
    chk("midrst stall", stall_o, 0);
    chk("midrst ctr", ctr_o, 0);
    chk("midrst lr", lr_o, 0);
    chk("midrst overflow", overflow_o, 0);
    @(negedge clk) begin rst_n = 1'b1; stall_i = 0; end
    repeat (4) @(negedge clk);
    chk("post-rst no result", outValid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/branch_conditional_unit.md
Name: branch_conditional_unit

Overview:
- Back-end consumer of decoded B-form (Branch Conditional) packets issued by the decode stage.
- Queues packets and resolves the BO/BI condition against a CR snapshot. Owns the architectural CTR and LR.
- Produces taken/next-address results in program order for the redirect and retire logic.
- Two-stage pipeline: a 2-entry input queue, then a resolve/output register.

Parameters:
- addressWidth, 64, instruction address width
- instructionCounterWidth, 64, major ID width
- opcodeSize, 12, decoded opcode width
- bodySize, 28, decoded B-form body width: BO[0:4], BI[5:9], BD||00[10:25], AA[26], LK[27]
- queueDepth, 2, input queue entries
- bcOpcode, 24, decoded opcode for Branch Conditional

Ports:
- clock_i  in  1  clock
- reset_i  in  1  asynchronous, active-low reset
- enable_i  in  1  decoded packet valid
- opcode_i  in  12  decoded opcode
- instructionAddress_i  in  64  CIA of the packet
- instMajId_i  in  64  major ID
- is64Bit_i  in  1  64-bit mode
- instructionBody_i  in  28  B-form body
- crBits_i  in  32  CR snapshot; bit 0 is CR MSB
- ctrWrEn_i  in  1  mtctr write
- ctrWrData_i  in  64  mtctr data
- lrWrEn_i  in  1  mtlr write
- lrWrData_i  in  64  mtlr data
- stall_i  in  1  downstream cannot take a result
- stall_o  out  1  queue full; decoder must hold
- outValid_o  out  1  result valid
- taken_o  out  1  branch taken
- nextAddress_o  out  64  NIA
- majId_o  out  64  major ID of the result
- illegal_o  out  1  opcode_i was not bcOpcode
- overflow_o  out  1  sticky: enable_i was seen while full
- ctr_o  out  64  architectural CTR
- lr_o  out  64  architectural LR

Behaviour:
- Reset (async, reset_i=0):
  - All outputs 0; CTR=0, LR=0; queue empty.
  - Reset mid-operation discards queued and in-flight packets with no CTR/LR update.
- Queue:
  - stall_o = (count==queueDepth), driven from the registered count.
  - A packet is pushed at the edge where enable_i=1 and count<queueDepth.
  - enable_i=1 while count==queueDepth: packet dropped; overflow_o sets and holds until reset.
  - Push and pop in the same cycle leave count unchanged; FIFO order is preserved.
- Resolve (pop):
  - Occurs when the queue is non-empty and (!outValid_o || !stall_i).
  - The output register loads at that edge. If nothing pops and !stall_i, outValid_o clears.
  - Latency: push at edge t → outValid_o at edge t+1 when the queue was empty and the output was free.
  - Throughput: 1 per cycle.
- Resolve arithmetic for a bcOpcode packet:
  - If BO[2]==0: CTRn=CTR-1, 64-bit wrap (0 → all ones). Otherwise CTRn=CTR.
  - ctrOk = BO[2] | ((CTRm!=0) ^ BO[3]). CTRm is CTRn[0:63] when is64Bit_i=1, else its low 32 bits.
  - condOk = BO[0] | (crBits_i[BI]==BO[1]). BI uses only bits 3:4 of a 5-bit field? No: BI is 0..31 and indexes crBits_i directly.
  - taken = ctrOk & condOk.
  - EA = sign-extend-64(BD||00). target = AA ? EA : CIA+EA.
  - nextAddress = taken ? target : CIA+4. When is64Bit_i=0, nextAddress[0:31] is forced to 0.
  - When LK=1: LR ← CIA+4, high half zeroed in 32-bit mode.
  - CTR ← CTRn.
- Non-bcOpcode packet: completes with illegal_o=1, taken_o=0, nextAddress_o=CIA+4, no CTR/LR change.
- Same-cycle conflicts: ctrWrEn_i/lrWrEn_i take priority over branch updates; the branch-computed value is discarded. The resolve still uses the pre-edge CTR.
- Back-to-back bc packets: the second one sees the CTR updated by the first.

Optional Feature:
- Macro BC_MISPREDICT_EN.
- Enabled:
  - Adds output mispredict_o, registered with the result.
  - Static prediction: taken iff BD is negative, or BO[0]&BO[2] (branch always).
  - mispredict_o = predicted != taken_o, for legal packets only.
- Disabled: port absent, no logic.

Decomposition:
- bc_pkg holds:
  - bcOpcode=24, BranchUnitID=6.
  - Body field offsets (BO, BI, BD, AA, LK).
  - The queue entry struct: opcode, CIA, majId, is64Bit, body.
- One sub-module: bc_input_queue, a generic 2-entry FIFO with count/full/empty and overflow flag.

Test Plan:
- Reset: drop reset_i mid-stream with 2 queued packets → outValid_o=0, stall_o=0, CTR=LR=0 immediately; no result appears after release.
- Branch-always: BO=10100, BD||00=0x0040, AA=0, LK=0, CIA=0x1000 → outValid one cycle after push, taken_o=1, nextAddress_o=0x1040, CTR unchanged.
- bdnz: mtctr 2; two bc BO=10000 packets → first taken with CTR=1; second not taken with CTR=0 and NIA=CIA+4. Third packet from CTR=0 → CTR=0xFFFF_FFFF_FFFF_FFFF, taken.
- CR test with link: BO=01100, BI=2, crBits_i=0x2000_0000, LK=1, CIA=0x2000 → taken, LR=0x2004. Same with is64Bit_i=0, AA=1, BD||00=0xFFF0 → NIA=0x0000_0000_FFFF_FFF0.
- Backpressure: stall_i=1 for 4 cycles with 4 pushes → stall_o rises after the queue fills, 4th push dropped, overflow_o=1. After release, results emerge in majId order.
- Illegal/conflict: opcode_i=5 → illegal_o=1, CTR/LR unchanged. bdnz resolving the same cycle as ctrWrEn_i=1, data 0x55 → CTR=0x55.
